// File: rtl/rob_commit_unit.sv
// In-order retirement at the ROB head: writeback, predictor training,
// store handshake, and flush/redirect on mispredict or exception.
module rob_commit_unit #(
  parameter int          ROB_ADDR_W = 4,
  parameter int          GHR_W      = 5,
  parameter int          EXC_W      = 8,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  can_commit,
  input  logic [ROB_ADDR_W-1:0] head_addr,
  input  logic                  head_done,
  input  logic                  head_reg_write_en,
  input  logic [4:0]            head_reg_write_addr,
  input  logic [31:0]           head_value,
  input  logic                  head_is_branch,
  input  logic                  head_is_jump,
  input  logic                  head_pred_taken,
  input  logic                  head_taken,
  input  logic [31:0]           head_target,
  input  logic [GHR_W-1:0]      head_pht_index,
  input  logic                  head_is_delayslot,
  input  logic                  head_mem_write,
  input  logic [3:0]            head_mem_sel,
  input  logic [31:0]           head_mem_data,
  input  logic [EXC_W-1:0]      head_exc_type,
  input  logic [31:0]           head_pc,
  output logic                  commit_en,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic [ROB_ADDR_W-1:0] rf_wtag,
  output logic                  store_valid,
  input  logic                  store_ready,
  output logic [31:0]           store_addr,
  output logic [31:0]           store_data,
  output logic [3:0]            store_sel,
  output logic                  pht_update_en,
  output logic [GHR_W-1:0]      pht_update_index,
  output logic                  pht_update_taken,
  output logic                  erase_en,
  output logic [ROB_ADDR_W-1:0] erase_from_addr,
  output logic                  flush_en,
  output logic [31:0]           redirect_pc,
  output logic                  exc_valid,
  output logic [EXC_W-1:0]      exc_code,
  output logic [31:0]           exc_epc,
  output logic                  exc_bd
);

  typedef enum logic [1:0] {
    RUN, STORE_WAIT, DS_WAIT, FLUSH
  } state_t;

  state_t                state, state_d;
  logic [31:0]           tgt, tgt_d;
  logic                  ds_st, ds_st_d;
  logic [ROB_ADDR_W-1:0] ds_tag, ds_tag_d;

  logic                  rf_we_d, sv_d, pht_en_d, pht_tk_d;
  logic                  erase_d, flush_d, exc_v_d, exc_bd_d;
  logic [4:0]            rf_waddr_d;
  logic [31:0]           rf_wdata_d, st_addr_d, st_data_d;
  logic [31:0]           redir_d, epc_d;
  logic [3:0]            st_sel_d;
  logic [ROB_ADDR_W-1:0] rf_wtag_d, erase_from_d;
  logic [GHR_W-1:0]      pht_idx_d;
  logic [EXC_W-1:0]      exc_code_d;

  logic ready, has_exc, mispred;

  assign ready   = can_commit && head_done;
  assign has_exc = head_exc_type != '0;
  assign mispred = head_is_branch && !head_is_jump &&
                   (head_pred_taken != head_taken);

  // Next-state, commit decision and next values of registered outputs
  always_comb begin
    state_d      = state;
    tgt_d        = tgt;
    ds_st_d      = ds_st;
    ds_tag_d     = ds_tag;
    commit_en    = 1'b0;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr;
    rf_wdata_d   = rf_wdata;
    rf_wtag_d    = rf_wtag;
    sv_d         = store_valid;
    st_addr_d    = store_addr;
    st_data_d    = store_data;
    st_sel_d     = store_sel;
    pht_en_d     = 1'b0;
    pht_idx_d    = pht_update_index;
    pht_tk_d     = pht_update_taken;
    erase_d      = 1'b0;
    erase_from_d = erase_from_addr;
    flush_d      = 1'b0;
    redir_d      = redirect_pc;
    exc_v_d      = 1'b0;
    exc_code_d   = exc_code;
    epc_d        = exc_epc;
    exc_bd_d     = exc_bd;
    unique case (state)
      RUN, DS_WAIT: begin
        if (ready) begin
          if (has_exc) begin
            commit_en    = 1'b1;
            exc_v_d      = 1'b1;
            exc_code_d   = head_exc_type;
            epc_d        = head_is_delayslot ? head_pc - 32'd4 : head_pc;
            exc_bd_d     = head_is_delayslot;
            flush_d      = 1'b1;
            erase_d      = 1'b1;
            erase_from_d = head_addr + 1'b1;
            redir_d      = EXC_VECTOR;
            state_d      = FLUSH;
          end else if (head_mem_write) begin
            sv_d      = 1'b1;
            st_addr_d = head_value;
            st_data_d = head_mem_data;
            st_sel_d  = head_mem_sel;
            ds_st_d   = state == DS_WAIT;
            ds_tag_d  = head_addr;
            state_d   = STORE_WAIT;
          end else begin
            commit_en  = 1'b1;
            rf_we_d    = head_reg_write_en;
            rf_waddr_d = head_reg_write_addr;
            rf_wdata_d = head_value;
            rf_wtag_d  = head_addr;
            if (head_is_branch) begin
              pht_en_d  = 1'b1;
              pht_idx_d = head_pht_index;
              pht_tk_d  = head_taken;
            end
            if (state == DS_WAIT) begin
              flush_d      = 1'b1;
              erase_d      = 1'b1;
              erase_from_d = head_addr + 1'b1;
              redir_d      = tgt;
              state_d      = FLUSH;
            end else if (mispred) begin
              tgt_d   = head_taken ? head_target : head_pc + 32'd8;
              state_d = DS_WAIT;
            end
          end
        end
      end
      STORE_WAIT: begin
        if (store_ready) begin
          commit_en = 1'b1;
          sv_d      = 1'b0;
          if (ds_st) begin
            ds_st_d      = 1'b0;
            flush_d      = 1'b1;
            erase_d      = 1'b1;
            erase_from_d = ds_tag + 1'b1;
            redir_d      = tgt;
            state_d      = FLUSH;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State and registered output update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= RUN;
      tgt              <= '0;
      ds_st            <= 1'b0;
      ds_tag           <= '0;
      rf_we            <= 1'b0;
      rf_waddr         <= '0;
      rf_wdata         <= '0;
      rf_wtag          <= '0;
      store_valid      <= 1'b0;
      store_addr       <= '0;
      store_data       <= '0;
      store_sel        <= '0;
      pht_update_en    <= 1'b0;
      pht_update_index <= '0;
      pht_update_taken <= 1'b0;
      erase_en         <= 1'b0;
      erase_from_addr  <= '0;
      flush_en         <= 1'b0;
      redirect_pc      <= '0;
      exc_valid        <= 1'b0;
      exc_code         <= '0;
      exc_epc          <= '0;
      exc_bd           <= 1'b0;
    end else begin
      state            <= state_d;
      tgt              <= tgt_d;
      ds_st            <= ds_st_d;
      ds_tag           <= ds_tag_d;
      rf_we            <= rf_we_d;
      rf_waddr         <= rf_waddr_d;
      rf_wdata         <= rf_wdata_d;
      rf_wtag          <= rf_wtag_d;
      store_valid      <= sv_d;
      store_addr       <= st_addr_d;
      store_data       <= st_data_d;
      store_sel        <= st_sel_d;
      pht_update_en    <= pht_en_d;
      pht_update_index <= pht_idx_d;
      pht_update_taken <= pht_tk_d;
      erase_en         <= erase_d;
      erase_from_addr  <= erase_from_d;
      flush_en         <= flush_d;
      redirect_pc      <= redir_d;
      exc_valid        <= exc_v_d;
      exc_code         <= exc_code_d;
      exc_epc          <= epc_d;
      exc_bd           <= exc_bd_d;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: ALU, stall, store,
// mispredict, delay-slot exception and async reset cases.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        can_commit;
  logic [3:0]  head_addr;
  logic        head_done;
  logic        head_reg_write_en;
  logic [4:0]  head_reg_write_addr;
  logic [31:0] head_value;
  logic        head_is_branch;
  logic        head_is_jump;
  logic        head_pred_taken;
  logic        head_taken;
  logic [31:0] head_target;
  logic [4:0]  head_pht_index;
  logic        head_is_delayslot;
  logic        head_mem_write;
  logic [3:0]  head_mem_sel;
  logic [31:0] head_mem_data;
  logic [7:0]  head_exc_type;
  logic [31:0] head_pc;
  logic        commit_en;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_wtag;
  logic        store_valid;
  logic        store_ready;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [3:0]  store_sel;
  logic        pht_update_en;
  logic [4:0]  pht_update_index;
  logic        pht_update_taken;
  logic        erase_en;
  logic [3:0]  erase_from_addr;
  logic        flush_en;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic [7:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .rst(rst),
    .can_commit(can_commit), .head_addr(head_addr),
    .head_done(head_done),
    .head_reg_write_en(head_reg_write_en),
    .head_reg_write_addr(head_reg_write_addr),
    .head_value(head_value), .head_is_branch(head_is_branch),
    .head_is_jump(head_is_jump),
    .head_pred_taken(head_pred_taken), .head_taken(head_taken),
    .head_target(head_target), .head_pht_index(head_pht_index),
    .head_is_delayslot(head_is_delayslot),
    .head_mem_write(head_mem_write), .head_mem_sel(head_mem_sel),
    .head_mem_data(head_mem_data), .head_exc_type(head_exc_type),
    .head_pc(head_pc), .commit_en(commit_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_wtag(rf_wtag), .store_valid(store_valid),
    .store_ready(store_ready), .store_addr(store_addr),
    .store_data(store_data), .store_sel(store_sel),
    .pht_update_en(pht_update_en),
    .pht_update_index(pht_update_index),
    .pht_update_taken(pht_update_taken),
    .erase_en(erase_en), .erase_from_addr(erase_from_addr),
    .flush_en(flush_en), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    can_commit = 0; head_addr = 0; head_done = 0;
    head_reg_write_en = 0; head_reg_write_addr = 0;
    head_value = 0; head_is_branch = 0; head_is_jump = 0;
    head_pred_taken = 0; head_taken = 0; head_target = 0;
    head_pht_index = 0; head_is_delayslot = 0;
    head_mem_write = 0; head_mem_sel = 0; head_mem_data = 0;
    head_exc_type = 0; head_pc = 0; store_ready = 0;
  endtask

  task automatic alu(input logic [3:0] tag, input logic [31:0] pc,
                     input logic [4:0] rd, input logic [31:0] val);
    clr();
    can_commit = 1; head_done = 1; head_addr = tag; head_pc = pc;
    head_reg_write_en = 1; head_reg_write_addr = rd;
    head_value = val;
  endtask

  initial begin
    clr();
    rst = 0;
    #12;
    chk("rst_commit", commit_en, 0);
    chk("rst_sv", store_valid, 0);
    chk("rst_flush", flush_en, 0);
    chk("rst_redir", redirect_pc, 0);
    chk("rst_epc", exc_epc, 0);
    chk("rst_rfwe", rf_we, 0);
    rst = 1;
    tick();

    // ALU entry
    alu(4'd0, 32'hbfc00000, 5'd3, 32'h1234);
    #1 chk("alu_commit", commit_en, 1);
    tick();
    clr();
    chk("alu_rfwe", rf_we, 1);
    chk("alu_waddr", rf_waddr, 3);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_wtag", rf_wtag, 0);
    chk("alu_flush", flush_en, 0);
    tick();
    chk("alu_rfwe_pulse", rf_we, 0);

    // Not done for 3 cycles
    alu(4'd1, 32'hbfc00004, 5'd5, 32'h55);
    head_done = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("nd_commit", commit_en, 0);
      tick();
      chk("nd_rfwe", rf_we, 0);
    end
    head_done = 1;
    #1 chk("nd_commit_rise", commit_en, 1);
    tick();
    clr();
    chk("nd_rfwe_after", rf_we, 1);
    chk("nd_wtag", rf_wtag, 1);
    chk("nd_wdata", rf_wdata, 32'h55);

    // Store with store_ready low for 2 cycles
    clr();
    can_commit = 1; head_done = 1; head_addr = 4'd2;
    head_mem_write = 1; head_value = 32'h80000010;
    head_mem_data = 32'hdeadbeef; head_mem_sel = 4'hf;
    #1 chk("st_accept_commit", commit_en, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("st_sv_hold", store_valid, 1);
      chk("st_addr", store_addr, 32'h80000010);
      chk("st_data", store_data, 32'hdeadbeef);
      chk("st_sel", store_sel, 4'hf);
      #1 chk("st_wait_commit", commit_en, 0);
      tick();
    end
    chk("st_sv_3rd", store_valid, 1);
    chk("st_data_3rd", store_data, 32'hdeadbeef);
    store_ready = 1;
    #1 chk("st_hs_commit", commit_en, 1);
    tick();
    clr();
    chk("st_sv_drop", store_valid, 0);
    alu(4'd3, 32'hbfc00008, 5'd7, 32'h77);
    #1 chk("st_back_run", commit_en, 1);
    tick();
    clr();
    chk("st_next_rfwe", rf_we, 1);

    // Mispredicted branch tag 14, delay slot tag 15
    clr();
    can_commit = 1; head_done = 1; head_addr = 4'd14;
    head_pc = 32'hbfc00010; head_is_branch = 1;
    head_pred_taken = 0; head_taken = 1;
    head_target = 32'hbfc00100; head_pht_index = 5'd9;
    #1 chk("mp_br_commit", commit_en, 1);
    tick();
    chk("mp_pht_en", pht_update_en, 1);
    chk("mp_pht_idx", pht_update_index, 9);
    chk("mp_pht_tk", pht_update_taken, 1);
    chk("mp_no_flush", flush_en, 0);
    clr();
    can_commit = 1; head_done = 1; head_addr = 4'd15;
    head_pc = 32'hbfc00014; head_is_delayslot = 1;
    #1 chk("mp_ds_commit", commit_en, 1);
    tick();
    chk("mp_flush", flush_en, 1);
    chk("mp_erase", erase_en, 1);
    chk("mp_erase_from", erase_from_addr, 0);
    chk("mp_redir", redirect_pc, 32'hbfc00100);
    chk("mp_pht_pulse", pht_update_en, 0);
    alu(4'd0, 32'hbfc00100, 5'd1, 32'h1);
    #1 chk("mp_flush_commit", commit_en, 0);
    tick();
    chk("mp_flush_drop", flush_en, 0);
    chk("mp_erase_drop", erase_en, 0);
    #1 chk("mp_run_again", commit_en, 1);
    clr();
    tick();

    // Delay-slot exception after a mispredicted branch
    clr();
    can_commit = 1; head_done = 1; head_addr = 4'd3;
    head_pc = 32'hbfc00010; head_is_branch = 1;
    head_pred_taken = 1; head_taken = 0;
    head_target = 32'hbfc00200;
    #1 chk("dx_br_commit", commit_en, 1);
    tick();
    chk("dx_pht_tk", pht_update_taken, 0);
    clr();
    can_commit = 1; head_done = 1; head_addr = 4'd4;
    head_pc = 32'hbfc00014; head_is_delayslot = 1;
    head_exc_type = 8'd4; head_reg_write_en = 1;
    #1 chk("dx_commit", commit_en, 1);
    tick();
    clr();
    chk("dx_exc_valid", exc_valid, 1);
    chk("dx_exc_code", exc_code, 4);
    chk("dx_epc", exc_epc, 32'hbfc00010);
    chk("dx_bd", exc_bd, 1);
    chk("dx_redir", redirect_pc, 32'hbfc00380);
    chk("dx_flush", flush_en, 1);
    chk("dx_erase_from", erase_from_addr, 5);
    chk("dx_no_rf", rf_we, 0);
    tick();
    chk("dx_exc_pulse", exc_valid, 0);
    alu(4'd5, 32'hbfc00380, 5'd2, 32'h22);
    #1 chk("dx_run_commit", commit_en, 1);
    tick();
    clr();
    chk("dx_tgt_dropped", flush_en, 0);
    chk("dx_run_rfwe", rf_we, 1);

    // Async reset while waiting on a store
    clr();
    can_commit = 1; head_done = 1; head_addr = 4'd6;
    head_mem_write = 1; head_value = 32'h80000020;
    head_mem_data = 32'h0badf00d; head_mem_sel = 4'h3;
    tick();
    chk("ar_sv_before", store_valid, 1);
    store_ready = 1;
    rst = 0;
    #1;
    chk("ar_sv_cleared", store_valid, 0);
    chk("ar_no_commit", commit_en, 0);
    tick();
    chk("ar_held_commit", commit_en, 0);
    clr();
    rst = 1;
    alu(4'd6, 32'hbfc00020, 5'd9, 32'h99);
    #1 chk("ar_new_commit", commit_en, 1);
    tick();
    clr();
    chk("ar_rfwe", rf_we, 1);
    chk("ar_sv_stays", store_valid, 0);
    chk("ar_wtag", rf_wtag, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
